// File: rtl/div_pkg.sv
`default_nettype none
// div_pkg: shared types, defaults and the ratio legality rule for the fractional-N sequencer.
// Rev 1.0
package div_pkg;

  localparam int DEF_P_WIDTH = 5;
  localparam int DEF_S_WIDTH = 3;
  localparam int DEF_F_WIDTH = 16;
  localparam int M           = 1 << DEF_S_WIDTH;
  // Signed modulator carry: -3..+4 in the MASH build, 0..1 otherwise.
  localparam int C_WIDTH     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic logic ratio_legal(input int ni, input int p_w, input int s_w);
    int pi;
    int si;
    pi = ni >>> s_w;
    si = ni & ((1 << s_w) - 1);
    return (ni >= 0) && (ni < (1 << (p_w + s_w))) && (pi > si) && (pi != 0);
  endfunction

  function automatic logic signed [C_WIDTH-1:0] carry_ext(input logic b);
    return {{(C_WIDTH-1){1'b0}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsm_mash.sv
`default_nettype none
// dsm_mash: delta-sigma carry generator stepped by the divider load strobe.
// DIV_RATIO_MASH111_EN selects MASH 1-1-1; otherwise a single first-order accumulator. Rev 1.0
module dsm_mash
  import div_pkg::*;
#(
  parameter int F_WIDTH = DEF_F_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [F_WIDTH-1:0]        frac_i,
  output logic signed [C_WIDTH-1:0] c_o
);

`ifdef DIV_RATIO_MASH111_EN
  logic [F_WIDTH-1:0] acc1_q, acc2_q, acc3_q;
  logic               c2_q, c3_q, c3_qq;
  logic [F_WIDTH:0]   acc1_d, acc2_d, acc3_d;

  // Each stage integrates the residue left by the previous one.
  assign acc1_d = {1'b0, acc1_q} + {1'b0, frac_i};
  assign acc2_d = {1'b0, acc2_q} + {1'b0, acc1_d[F_WIDTH-1:0]};
  assign acc3_d = {1'b0, acc3_q} + {1'b0, acc2_d[F_WIDTH-1:0]};

  assign c_o = carry_ext(acc1_d[F_WIDTH])
             + carry_ext(acc2_d[F_WIDTH]) - carry_ext(c2_q)
             + carry_ext(acc3_d[F_WIDTH]) - (carry_ext(c3_q) <<< 1) + carry_ext(c3_qq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      acc3_q <= '0;
      c2_q   <= 1'b0;
      c3_q   <= 1'b0;
      c3_qq  <= 1'b0;
    end else if (clr_i) begin
      acc1_q <= '0;
      acc2_q <= '0;
      acc3_q <= '0;
      c2_q   <= 1'b0;
      c3_q   <= 1'b0;
      c3_qq  <= 1'b0;
    end else if (en_i) begin
      acc1_q <= acc1_d[F_WIDTH-1:0];
      acc2_q <= acc2_d[F_WIDTH-1:0];
      acc3_q <= acc3_d[F_WIDTH-1:0];
      c2_q   <= acc2_d[F_WIDTH];
      c3_q   <= acc3_d[F_WIDTH];
      c3_qq  <= c3_q;
    end
  end
`else
  logic [F_WIDTH-1:0] acc_q;
  logic [F_WIDTH:0]   acc_d;

  assign acc_d = {1'b0, acc_q} + {1'b0, frac_i};
  assign c_o   = carry_ext(acc_d[F_WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d[F_WIDTH-1:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/div_ratio_ctrl.sv
`default_nettype none
// div_ratio_ctrl: fractional-N divide-ratio sequencer producing Pi/Si per divide cycle.
// Build option DIV_RATIO_MASH111_EN (in dsm_mash) selects the MASH 1-1-1 modulator. Rev 1.0
module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int P_WIDTH = DEF_P_WIDTH,
  parameter int S_WIDTH = DEF_S_WIDTH,
  parameter int F_WIDTH = DEF_F_WIDTH
) (
  input  logic                       Fin,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [P_WIDTH+S_WIDTH-1:0] cfg_n,
  input  logic [F_WIDTH-1:0]         cfg_frac,
  input  logic                       ld,
  output logic [P_WIDTH-1:0]         Pi,
  output logic [S_WIDTH-1:0]         Si,
  output logic                       running,
  output logic                       err
);

  localparam int N_W = P_WIDTH + S_WIDTH;
  localparam int I_W = N_W + 2;

  state_t               state_q;
  logic [N_W-1:0]       n_act_q, n_pend_q;
  logic [F_WIDTH-1:0]   frac_act_q, frac_pend_q;
  logic                 pend_q;
  logic [P_WIDTH-1:0]   pi_q;
  logic [S_WIDTH-1:0]   si_q;
  logic                 err_q;

  logic                      hs;
  logic                      step;
  logic [N_W-1:0]            n_eff;
  logic [F_WIDTH-1:0]        frac_eff;
  logic signed [C_WIDTH-1:0] c;
  logic signed [I_W-1:0]     ni_d;
  logic                      ni_legal;
  logic                      cfg_legal;

  assign cfg_ready = ~pend_q;
  assign hs        = cfg_valid & cfg_ready;
  assign step      = ld & (state_q != ST_IDLE);

  // A pending config takes effect on the very ld that applies it.
  assign n_eff    = pend_q ? n_pend_q    : n_act_q;
  assign frac_eff = pend_q ? frac_pend_q : frac_act_q;

  assign ni_d      = $signed({2'b00, n_eff}) + $signed({{(I_W-C_WIDTH){c[C_WIDTH-1]}}, c});
  assign ni_legal  = ratio_legal(int'(ni_d), P_WIDTH, S_WIDTH);
  assign cfg_legal = ratio_legal(int'(cfg_n), P_WIDTH, S_WIDTH);

  dsm_mash #(
    .F_WIDTH (F_WIDTH)
  ) u_dsm (
    .clk    (Fin),
    .rst    (rst),
    .clr_i  (hs && (state_q == ST_IDLE)),
    .en_i   (step),
    .frac_i (frac_eff),
    .c_o    (c)
  );

  always_ff @(posedge Fin or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_act_q     <= '0;
      frac_act_q  <= '0;
      n_pend_q    <= '0;
      frac_pend_q <= '0;
      pend_q      <= 1'b0;
      pi_q        <= '0;
      si_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            n_act_q    <= cfg_n;
            frac_act_q <= cfg_frac;
            err_q      <= ~cfg_legal;
            state_q    <= ST_ARM;
          end
        end
        ST_ARM, ST_RUN: begin
          if (ld) begin
            state_q <= ST_RUN;
            if (ni_legal) begin
              pi_q <= ni_d[N_W-1:S_WIDTH];
              si_q <= ni_d[S_WIDTH-1:0];
            end
            // Applying a config clears the sticky flag before judging the new ratio.
            err_q <= (err_q & ~pend_q) | ~ni_legal;
            if (pend_q) begin
              n_act_q    <= n_pend_q;
              frac_act_q <= frac_pend_q;
              pend_q     <= 1'b0;
            end
          end
          if (hs) begin
            n_pend_q    <= cfg_n;
            frac_pend_q <= cfg_frac;
            pend_q      <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Pi      = pi_q;
  assign Si      = si_q;
  assign err     = err_q;
  assign running = (state_q == ST_RUN);

endmodule
`default_nettype wire
